rob_core: RTL

- In-order reorder buffer for the Tomasulo-style out-of-order core.
- Sits downstream of the ALU reservation station. Consumes its (target, result) writeback.
- Drives the per-entry snoop vectors that reservation stations use to capture operands.
- Dispatch allocates entries in program order. Commit retires the head entry to the register file, one per cycle.

---
 rtl/rob_core_pkg.sv | 31 +++
 rtl/rob_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rob_core_pkg.sv
// =============================================================================
// Module      : rob_core_pkg
// Description : Shared ROB constants and entry type, also used by reservation
//               station snoop logic.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package rob_core_pkg;

    localparam int ROB_TAG_W     = 4;
    localparam int ROB_ENTRY_NUM = 8;
    localparam int COMMON_WIDTH  = 32;
    localparam int ROB_REG_W     = 5;

    localparam logic [ROB_TAG_W-1:0] TAG_INVALID = {ROB_TAG_W{1'b1}};

    typedef struct packed {
        logic                    valid;
        logic                    ready;
        logic [ROB_REG_W-1:0]    dest;
        logic [COMMON_WIDTH-1:0] val;
    } rob_entry_t;

    function automatic logic tag_in_rob(input logic [ROB_TAG_W-1:0] tag);
        return (tag != TAG_INVALID) && (tag < ROB_TAG_W'(ROB_ENTRY_NUM));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_core.sv
// =============================================================================
// Module      : rob_core
// Description : In-order reorder buffer. Allocates in program order, captures
//               out-of-order writebacks, retires the head one entry per cycle.
//               Optional synchronous flush port when ROB_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rob_core
    import rob_core_pkg::*;
#(
    parameter int ENTRY_NUM = ROB_ENTRY_NUM,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int DATA_W    = COMMON_WIDTH,
    parameter int REG_W     = ROB_REG_W
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef ROB_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        alloc_valid,
    input  logic [REG_W-1:0]            alloc_dest,
    output logic                        alloc_ready,
    output logic [TAG_W-1:0]            alloc_tag,
    input  logic [TAG_W-1:0]            wb_target,
    input  logic [DATA_W-1:0]           wb_result,
    output logic [ENTRY_NUM-1:0]        snoop_valid,
    output logic [ENTRY_NUM-1:0]        snoop_ready,
    output logic [ENTRY_NUM*DATA_W-1:0] snoop_val,
    output logic                        commit_valid,
    output logic [TAG_W-1:0]            commit_tag,
    output logic [REG_W-1:0]            commit_dest,
    output logic [DATA_W-1:0]           commit_val,
    output logic [TAG_W-1:0]            count
);

    localparam int               c_PTR_W       = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam logic [TAG_W-1:0] c_TAG_INVALID = {TAG_W{1'b1}};
    localparam logic [TAG_W-1:0] c_COUNT_FULL  = TAG_W'(ENTRY_NUM);

    logic [ENTRY_NUM-1:0] r_valid;
    logic [ENTRY_NUM-1:0] r_ready;
    logic [DATA_W-1:0]    r_val  [ENTRY_NUM];
    logic [REG_W-1:0]     r_dest [ENTRY_NUM];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [TAG_W-1:0]     r_count;

    logic                 r_commit_valid;
    logic [TAG_W-1:0]     r_commit_tag;
    logic [REG_W-1:0]     r_commit_dest;
    logic [DATA_W-1:0]    r_commit_val;

    logic                 w_flush;
    logic                 w_alloc_ready;
    logic                 w_alloc_fire;
    logic                 w_wb_in_range;
    logic [c_PTR_W-1:0]   w_wb_idx;
    logic                 w_wb_fire;
    logic                 w_commit_fire;
    logic [TAG_W-1:0]     w_count_nxt;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_alloc_ready = (r_count < c_COUNT_FULL);
    assign w_alloc_fire  = alloc_valid && w_alloc_ready;

    // The slice is only meaningful once the tag is known to be in range.
    assign w_wb_in_range = (wb_target != c_TAG_INVALID) && (wb_target < c_COUNT_FULL);
    assign w_wb_idx      = wb_target[c_PTR_W-1:0];
    assign w_wb_fire     = w_wb_in_range && r_valid[w_wb_idx];

    assign w_commit_fire = r_valid[r_head] && r_ready[r_head];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_alloc_fire, w_commit_fire})
            2'b10:   w_count_nxt = r_count + TAG_W'(1);
            2'b01:   w_count_nxt = r_count - TAG_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_commit_fire) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            if (w_alloc_fire) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Allocation and writeback never collide: writeback needs a valid entry and
    // the tail is only valid when full. Commit is last so it wins on the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_ready <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_val[i]  <= '0;
                r_dest[i] <= '0;
            end
        end else if (w_flush) begin
            r_valid <= '0;
            r_ready <= '0;
        end else begin
            if (w_wb_fire) begin
                r_val[w_wb_idx]   <= wb_result;
                r_ready[w_wb_idx] <= 1'b1;
            end
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_val[r_tail]   <= '0;
                r_dest[r_tail]  <= alloc_dest;
            end
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_commit_valid <= 1'b0;
            r_commit_tag   <= c_TAG_INVALID;
            r_commit_dest  <= '0;
            r_commit_val   <= '0;
        end else if (w_flush) begin
            r_commit_valid <= 1'b0;
        end else begin
            r_commit_valid <= w_commit_fire;
            if (w_commit_fire) begin
                r_commit_tag  <= TAG_W'(r_head);
                r_commit_dest <= r_dest[r_head];
                r_commit_val  <= r_val[r_head];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_snoop
            assign snoop_val[gi*DATA_W +: DATA_W] = r_val[gi];
        end
    endgenerate

    assign snoop_valid  = r_valid;
    assign snoop_ready  = r_ready;
    assign alloc_ready  = w_alloc_ready;
    assign alloc_tag    = TAG_W'(r_tail);
    assign count        = r_count;
    assign commit_valid = r_commit_valid;
    assign commit_tag   = r_commit_tag;
    assign commit_dest  = r_commit_dest;
    assign commit_val   = r_commit_val;

endmodule

`default_nettype wire
